// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-port unified memory between the IF-stage fetch port and
//   the MEM-stage data port. Data requests win arbitration unless a waiting
//   fetch has been passed over STARVE_MAX times in a row. Each access is
//   sequenced IDLE -> ISSUE -> WAIT -> RESP (stores skip WAIT), and per-port
//   stall signals are fed back to the pipeline hazard logic.
//
// Ports
//   clk_i, rst_i           clock (rising edge), synchronous active-high reset
//   if_req_i, if_addr_i    fetch request / address (req held until ack)
//   if_ack_o, if_rdata_o   fetch completion pulse / registered instruction
//   if_stall_o             fetch stall (req & ~ack, forced 0 in reset)
//   dm_req_i, dm_we_i      data request / store select (req held until ack)
//   dm_addr_i, dm_wdata_i  data address / store data
//   dm_ack_o, dm_rdata_o   data completion pulse / registered load data
//   dm_stall_o             data stall (req & ~ack, forced 0 in reset)
//   mem_en_o, mem_we_o     memory strobe (one cycle per access) / write enable
//   mem_addr_o, mem_wdata_o memory address / write data, zero outside ISSUE
//   mem_rdata_i            memory read data, valid MEM_LAT cycles after mem_en_o
//   busy_o                 arbiter is not idle

module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_stall_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_stall_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              grant_any;
  logic              grant_fetch;
  logic              owner_fetch_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  wait_q;
  logic [STV_W-1:0]  starve_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              rdata_hit;

  // The read word is on mem_rdata_i in the last WAIT cycle (ISSUE + MEM_LAT).
  assign rdata_hit = (state_q == WAIT) && (wait_q == CNT_W'(MEM_LAT));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and arbitration. Requests are only looked at in IDLE; data
  // wins a tie unless the fetch port has already been passed over
  // STARVE_MAX times in a row.
  always_comb begin
    state_d     = state_q;
    grant_any   = 1'b0;
    grant_fetch = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req_i || dm_req_i) begin
          grant_any   = 1'b1;
          grant_fetch = if_req_i && (!dm_req_i || (starve_q == STV_W'(STARVE_MAX)));
          state_d     = ISSUE;
        end
      end
      ISSUE:   state_d = we_q ? RESP : WAIT;
      WAIT:    state_d = rdata_hit ? RESP : WAIT;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Access context, latency counter, starvation counter and the two read
  // data registers. The context is frozen at grant time so later changes on
  // the request ports cannot disturb an access in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_fetch_q <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wait_q        <= '0;
      starve_q      <= '0;
      if_rdata_q    <= '0;
      dm_rdata_q    <= '0;
    end else begin
      if (grant_any) begin
        owner_fetch_q <= grant_fetch;
        we_q          <= grant_fetch ? 1'b0 : dm_we_i;
        addr_q        <= grant_fetch ? if_addr_i : dm_addr_i;
        wdata_q       <= grant_fetch ? '0 : dm_wdata_i;
        if (grant_fetch || !if_req_i) begin
          starve_q <= '0;
        end else if (starve_q != STV_W'(STARVE_MAX)) begin
          starve_q <= starve_q + STV_W'(1);
        end
      end

      if (state_q == ISSUE) begin
        wait_q <= CNT_W'(1);
      end else if (state_q == WAIT) begin
        wait_q <= wait_q + CNT_W'(1);
      end else begin
        wait_q <= '0;
      end

      if (rdata_hit) begin
        if (owner_fetch_q) begin
          if_rdata_q <= mem_rdata_i;
        end else begin
          dm_rdata_q <= mem_rdata_i;
        end
      end
    end
  end

  // Outputs decode from registered state only, except the stalls, which
  // must follow the request lines combinationally.
  assign if_ack_o    = (state_q == RESP) && owner_fetch_q;
  assign dm_ack_o    = (state_q == RESP) && !owner_fetch_q;
  assign if_stall_o  = if_req_i && !if_ack_o && !rst_i;
  assign dm_stall_o  = dm_req_i && !dm_ack_o && !rst_i;
  assign mem_en_o    = (state_q == ISSUE);
  assign mem_we_o    = mem_en_o && we_q;
  assign mem_addr_o  = mem_en_o ? addr_q : '0;
  assign mem_wdata_o = mem_en_o ? wdata_q : '0;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter
//   Directed bench for unified_mem_arbiter (MEM_LAT=2, STARVE_MAX=4). A small
//   memory model answers reads exactly MEM_LAT cycles after the strobe and
//   drives a poison value otherwise. Single transactions run from a
//   cycle-by-cycle vector table; arbitration, starvation and reset-abort
//   sequences are written out by hand.

module tb_unified_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        if_stall_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_ack_o;
  logic [31:0] dm_rdata_o;
  logic        dm_stall_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  unified_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o),
    .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
    .dm_stall_o(dm_stall_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory model: word array indexed by addr[11:2]; reads return two cycles
  // after the strobe, every other cycle carries a poison word.
  logic [31:0] bmem [0:1023];
  logic [31:0] rd_p0 = 32'hBAD0_BAD0;
  logic [31:0] rd_p1 = 32'hBAD0_BAD0;
  assign mem_rdata_i = rd_p1;

  always @(posedge clk_i) begin
    if (mem_en_o && mem_we_o) bmem[mem_addr_o[11:2]] = mem_wdata_o;
    rd_p0 <= (mem_en_o && !mem_we_o) ? bmem[mem_addr_o[11:2]] : 32'hBAD0_BAD0;
    rd_p1 <= rd_p0;
  end

  typedef struct packed {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        e_if_ack;
    logic        e_if_stall;
    logic        e_dm_ack;
    logic        e_dm_stall;
    logic        e_mem_en;
    logic        e_mem_we;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic        e_busy;
    logic [31:0] e_if_rdata;
    logic [31:0] e_dm_rdata;
  } vec_t;

  vec_t vecs[16];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_i      = v.rst;
    if_req_i   = v.if_req;
    if_addr_i  = v.if_addr;
    dm_req_i   = v.dm_req;
    dm_we_i    = v.dm_we;
    dm_addr_i  = v.dm_addr;
    dm_wdata_i = v.dm_wdata;
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_flags"},
                {24'd0, if_ack_o, if_stall_o, dm_ack_o, dm_stall_o, mem_en_o, mem_we_o, busy_o, 1'b0},
                32'd0);
    checkOutput({tag, "_mem_addr"}, mem_addr_o, 32'd0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
    checkOutput({tag, "_if_rdata"}, if_rdata_o, 32'd0);
    checkOutput({tag, "_dm_rdata"}, dm_rdata_o, 32'd0);
  endtask

  localparam logic [31:0] F  = 32'hDEAD_BEEF;
  localparam logic [31:0] L  = 32'h1234_5678;
  localparam logic [31:0] SD = 32'hCAFE_F00D;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int dm_ack_cyc, if_ack_cyc, if_issue_cyc, ngrant, drained;
    logic grant_i [10];
    logic exp_i   [10];

    for (int i = 0; i < 1024; i++) bmem[i] = 32'h0;
    bmem[32'h010 >> 2] = F;
    bmem[32'h020 >> 2] = 32'h0000_0013;
    bmem[32'h040 >> 2] = 32'h00A0_0093;
    bmem[32'h100 >> 2] = L;
    bmem[32'h104 >> 2] = 32'hBBBB_0104;
    bmem[32'h300 >> 2] = 32'h0000_0300;

    // rst if_req if_addr dm_req we dm_addr dm_wdata | ifack ifst dmack dmst en we addr wdata busy ifrd dmrd
    // Fetch 0x10; address change after grant must be ignored.
    vecs[0]  = '{1'b0,1'b1,32'h10,1'b0,1'b0,32'h0,32'h0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0,32'h0,32'h0};
    vecs[1]  = '{1'b0,1'b1,32'h44,1'b0,1'b0,32'h0,32'h0, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,32'h10,32'h0,1'b1,32'h0,32'h0};
    vecs[2]  = '{1'b0,1'b1,32'h44,1'b0,1'b0,32'h0,32'h0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b1,32'h0,32'h0};
    vecs[3]  = '{1'b0,1'b1,32'h44,1'b0,1'b0,32'h0,32'h0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b1,32'h0,32'h0};
    vecs[4]  = '{1'b0,1'b1,32'h44,1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b1,F,32'h0};
    vecs[5]  = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0,F,32'h0};
    // Load 0x100.
    vecs[6]  = '{1'b0,1'b0,32'h0,1'b1,1'b0,32'h100,32'h0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,32'h0,1'b0,F,32'h0};
    vecs[7]  = '{1'b0,1'b0,32'h0,1'b1,1'b0,32'h104,32'h0, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,32'h100,32'h0,1'b1,F,32'h0};
    vecs[8]  = '{1'b0,1'b0,32'h0,1'b1,1'b0,32'h104,32'h0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,32'h0,1'b1,F,32'h0};
    vecs[9]  = '{1'b0,1'b0,32'h0,1'b1,1'b0,32'h104,32'h0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,32'h0,1'b1,F,32'h0};
    vecs[10] = '{1'b0,1'b0,32'h0,1'b1,1'b0,32'h104,32'h0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,1'b1,F,L};
    vecs[11] = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,   1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0,F,L};
    // Store 0x200 <- CAFEF00D; address/data changes after grant ignored.
    vecs[12] = '{1'b0,1'b0,32'h0,1'b1,1'b1,32'h200,SD,        1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,32'h0,1'b0,F,L};
    vecs[13] = '{1'b0,1'b0,32'h0,1'b1,1'b1,32'hFFFF_FFFC,32'h0, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,32'h200,SD,1'b1,F,L};
    vecs[14] = '{1'b0,1'b0,32'h0,1'b1,1'b1,32'hFFFF_FFFC,32'h0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,1'b1,F,L};
    vecs[15] = '{1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,32'h0,       1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0,F,L};

    // Reset held 3 cycles with both requests high.
    rst_i = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h40;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h300; dm_wdata_i = 32'h0;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      @(negedge clk_i);
      checkIdleZero($sformatf("rst_hold%0d", i));
    end
    nextCycle();
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rel0_busy_en", {30'd0, busy_o, mem_en_o}, 32'd0);
    checkOutput("rel0_stalls", {30'd0, if_stall_o, dm_stall_o}, 32'd3);
    nextCycle();
    @(negedge clk_i);
    checkOutput("rel1_mem_en", {31'd0, mem_en_o}, 32'd1);
    checkOutput("rel1_mem_addr", mem_addr_o, 32'h300);
    // Abort from ISSUE to start the table from a clean state.
    nextCycle();
    rst_i = 1'b1; if_req_i = 1'b0; dm_req_i = 1'b0;
    nextCycle();
    rst_i = 1'b0;
    @(negedge clk_i);
    checkIdleZero("rst_clean");
    nextCycle();

    // Single fetch, load and store from the table.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk_i);
      checkOutput($sformatf("row%0d_if_ack", i),   {31'd0, if_ack_o},   {31'd0, vecs[i].e_if_ack});
      checkOutput($sformatf("row%0d_if_stall", i), {31'd0, if_stall_o}, {31'd0, vecs[i].e_if_stall});
      checkOutput($sformatf("row%0d_dm_ack", i),   {31'd0, dm_ack_o},   {31'd0, vecs[i].e_dm_ack});
      checkOutput($sformatf("row%0d_dm_stall", i), {31'd0, dm_stall_o}, {31'd0, vecs[i].e_dm_stall});
      checkOutput($sformatf("row%0d_mem_en", i),   {31'd0, mem_en_o},   {31'd0, vecs[i].e_mem_en});
      checkOutput($sformatf("row%0d_mem_we", i),   {31'd0, mem_we_o},   {31'd0, vecs[i].e_mem_we});
      checkOutput($sformatf("row%0d_mem_addr", i),  mem_addr_o,  vecs[i].e_mem_addr);
      checkOutput($sformatf("row%0d_mem_wdata", i), mem_wdata_o, vecs[i].e_mem_wdata);
      checkOutput($sformatf("row%0d_busy", i),     {31'd0, busy_o},     {31'd0, vecs[i].e_busy});
      checkOutput($sformatf("row%0d_if_rdata", i),  if_rdata_o,  vecs[i].e_if_rdata);
      checkOutput($sformatf("row%0d_dm_rdata", i),  dm_rdata_o,  vecs[i].e_dm_rdata);
      nextCycle();
    end

    // Simultaneous fetch 0x20 and load 0x100: load first, then fetch.
    dm_ack_cyc = -1; if_ack_cyc = -1; if_issue_cyc = -1;
    if_req_i = 1'b1; if_addr_i = 32'h20;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h100; dm_wdata_i = 32'h0;
    for (int c = 0; c < 30 && if_ack_cyc < 0; c++) begin
      @(negedge clk_i);
      if (dm_ack_o && dm_ack_cyc < 0) dm_ack_cyc = c;
      if (if_ack_o) if_ack_cyc = c;
      if (mem_en_o && mem_addr_o == 32'h20) if_issue_cyc = c;
      nextCycle();
      if (dm_ack_cyc == c) dm_req_i = 1'b0;
      if (if_ack_cyc == c) if_req_i = 1'b0;
    end
    checkOutput("t3_dm_ack_cycle", dm_ack_cyc, 32'd4);
    checkOutput("t3_if_issue_cycle", if_issue_cyc, 32'd6);
    checkOutput("t3_if_ack_cycle", if_ack_cyc, 32'd9);
    checkOutput("t3_if_rdata", if_rdata_o, 32'h0000_0013);
    checkOutput("t3_dm_rdata", dm_rdata_o, L);

    // Continuous loads and fetches: starvation guard order D,D,D,D,I x2.
    for (int k = 0; k < 10; k++) begin
      exp_i[k]   = (k == 4) || (k == 9);
      grant_i[k] = 1'b0;
    end
    ngrant = 0;
    if_req_i = 1'b1; if_addr_i = 32'h40;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h104;
    for (int c = 0; c < 100 && ngrant < 10; c++) begin
      @(negedge clk_i);
      if (mem_en_o) begin
        grant_i[ngrant] = (mem_addr_o == 32'h40);
        ngrant++;
      end
      nextCycle();
    end
    if_req_i = 1'b0; dm_req_i = 1'b0;
    checkOutput("t5_grant_count", ngrant, 32'd10);
    for (int k = 0; k < 10; k++)
      checkOutput($sformatf("t5_grant%0d_is_fetch", k), {31'd0, grant_i[k]}, {31'd0, exp_i[k]});
    drained = 0;
    for (int c = 0; c < 20 && !drained; c++) begin
      @(negedge clk_i);
      if (!busy_o) drained = 1;
      nextCycle();
    end
    checkOutput("t5_drained", drained, 32'd1);
    checkOutput("t5_if_rdata", if_rdata_o, 32'h00A0_0093);
    checkOutput("t5_dm_rdata", dm_rdata_o, 32'hBBBB_0104);

    // Reset pulse during WAIT of a load, then a retried load completes.
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h200;
    @(negedge clk_i);
    nextCycle();
    @(negedge clk_i);
    checkOutput("t6_issue", {31'd0, mem_en_o}, 32'd1);
    nextCycle();
    rst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("t6_rst_acks_stall", {29'd0, dm_ack_o, if_ack_o, dm_stall_o}, 32'd0);
    nextCycle();
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("t6_after_flags", {26'd0, busy_o, mem_en_o, mem_we_o, dm_ack_o, if_ack_o, 1'b0}, 32'd0);
    checkOutput("t6_after_mem_addr", mem_addr_o, 32'd0);
    checkOutput("t6_after_dm_rdata", dm_rdata_o, 32'd0);
    checkOutput("t6_after_if_rdata", if_rdata_o, 32'd0);
    checkOutput("t6_after_stall", {31'd0, dm_stall_o}, 32'd1);
    dm_ack_cyc = -1;
    nextCycle();
    for (int c = 1; c < 20 && dm_ack_cyc < 0; c++) begin
      @(negedge clk_i);
      if (dm_ack_o) dm_ack_cyc = c;
      nextCycle();
      if (dm_ack_cyc == c) dm_req_i = 1'b0;
    end
    checkOutput("t6_retry_ack_cycle", dm_ack_cyc, 32'd4);
    checkOutput("t6_retry_rdata", dm_rdata_o, SD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
